// File: rtl/urv_iram_loader.sv
// Framed byte-stream loader: parses 0xA5-framed WRITE/RUN/HALT commands into
// IRAM port-B word writes and controls the core reset line.
module urv_iram_loader #(
  parameter int unsigned g_size           = 65536,
  parameter int unsigned g_timeout_cycles = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        enb_o,
  output logic        web_o,
  output logic [31:0] ab_o,
  output logic [3:0]  bweb_o,
  output logic [31:0] db_o,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [31:0] c_mask = 32'(g_size - 1);
  localparam int c_tw = $clog2(g_timeout_cycles + 1);
  localparam logic [c_tw-1:0] c_tmo_last = c_tw'(g_timeout_cycles - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_CSUM
  } state_t;

  state_t          r_state;
  logic [7:0]      r_cmd;
  logic [7:0]      r_sum;
  logic [31:0]     r_addr;
  logic [15:0]     r_len;
  logic [23:0]     r_word;
  logic [1:0]      r_cnt;
  logic [c_tw-1:0] r_tmo;

  logic       w_acc;
  logic [7:0] w_sum_next;

  assign w_acc      = rx_valid_i & rx_ready_o;
  assign w_sum_next = r_sum + rx_data_i;

  // Frame parser, word assembly, timeout and all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cmd      <= 8'h00;
      r_sum      <= 8'h00;
      r_addr     <= 32'h0;
      r_len      <= 16'h0;
      r_word     <= 24'h0;
      r_cnt      <= 2'd0;
      r_tmo      <= '0;
      rx_ready_o <= 1'b0;
      enb_o      <= 1'b0;
      web_o      <= 1'b0;
      ab_o       <= 32'h0;
      bweb_o     <= 4'h0;
      db_o       <= 32'h0;
      cpu_rst_o  <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      rx_ready_o <= 1'b1;
      enb_o      <= 1'b0;
      web_o      <= 1'b0;
      ab_o       <= 32'h0;
      bweb_o     <= 4'h0;
      db_o       <= 32'h0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      if (w_acc) begin
        r_tmo <= '0;
        case (r_state)
          S_IDLE: begin
            if (rx_data_i == 8'hA5) begin
              r_state <= S_CMD;
              busy_o  <= 1'b1;
            end
          end
          S_CMD: begin
            r_sum <= rx_data_i;
            r_cmd <= rx_data_i;
            r_cnt <= 2'd0;
            case (rx_data_i)
              8'h01: begin
                cpu_rst_o <= 1'b1;
                r_state   <= S_ADDR;
              end
              8'h02, 8'h03: r_state <= S_CSUM;
              default: begin
                err_o   <= 1'b1;
                busy_o  <= 1'b0;
                r_state <= S_IDLE;
              end
            endcase
          end
          S_ADDR: begin
            // Bytes shift in from the top; by the 4th byte ADDR0 sits in [15:8].
            r_sum  <= w_sum_next;
            r_addr <= {rx_data_i, r_addr[31:8]};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_cnt <= 2'd0;
              if (r_addr[9:8] != 2'b00) begin
                err_o   <= 1'b1;
                busy_o  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_LEN;
              end
            end
          end
          S_LEN: begin
            r_sum <= w_sum_next;
            r_len <= {rx_data_i, r_len[15:8]};
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd1) begin
              r_cnt   <= 2'd0;
              r_state <= ({rx_data_i, r_len[15:8]} == 16'h0) ? S_CSUM : S_DATA;
            end
          end
          S_DATA: begin
            r_sum  <= w_sum_next;
            r_word <= {rx_data_i, r_word[23:8]};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              enb_o  <= 1'b1;
              web_o  <= 1'b1;
              bweb_o <= 4'hF;
              ab_o   <= r_addr & c_mask;
              db_o   <= {rx_data_i, r_word};
              r_addr <= (r_addr + 32'd4) & c_mask;
              r_len  <= r_len - 16'd1;
              if (r_len == 16'd1) begin
                r_state <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            r_state <= S_IDLE;
            busy_o  <= 1'b0;
            if (rx_data_i == r_sum) begin
              done_o <= 1'b1;
              if (r_cmd == 8'h02) begin
                cpu_rst_o <= 1'b0;
              end else if (r_cmd == 8'h03) begin
                cpu_rst_o <= 1'b1;
              end
            end else begin
              err_o <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            busy_o  <= 1'b0;
          end
        endcase
      end else if (r_state == S_IDLE) begin
        r_tmo <= '0;
      end else if (r_tmo == c_tmo_last) begin
        // Stalled frame: abort; any partially assembled word is dropped.
        r_tmo   <= '0;
        err_o   <= 1'b1;
        busy_o  <= 1'b0;
        r_state <= S_IDLE;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_urv_iram_loader.sv
// Randomized scoreboard bench for urv_iram_loader: frame tasks push expected
// writes/events, a negedge monitor pops and compares against DUT outputs.
module tb_urv_iram_loader;
  localparam int G_SIZE = 65536;
  localparam int G_TMO  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready_o, enb_o, web_o, cpu_rst_o, busy_o, done_o, err_o;
  logic [31:0] ab_o, db_o;
  logic [3:0]  bweb_o;

  urv_iram_loader #(.g_size(G_SIZE), .g_timeout_cycles(G_TMO)) dut (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .rx_ready_o(rx_ready_o), .enb_o(enb_o), .web_o(web_o), .ab_o(ab_o),
    .bweb_o(bweb_o), .db_o(db_o), .cpu_rst_o(cpu_rst_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct { bit is_err; logic cpu; } ev_t;

  wr_t wq[$];
  ev_t eq[$];
  int total = 0;
  int bad = 0;
  bit m_cpu = 1'b1;
  bit mon_en = 1'b0;
  logic [31:0] wbuf [4];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Monitor: compare every port-B write and every done/err pulse with the queues.
  always @(negedge clk) begin
    wr_t w;
    ev_t e;
    if (mon_en && !rst) begin
      if (enb_o) begin
        if (wq.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
        else begin
          w = wq.pop_front();
          chk("write_addr", {32'h0, ab_o}, {32'h0, w.a});
          chk("write_data", {32'h0, db_o}, {32'h0, w.d});
          chk("write_ctrl", {59'h0, web_o, bweb_o}, {59'h0, 1'b1, 4'hF});
        end
      end else if (web_o || (bweb_o != 4'h0) || (ab_o != 32'h0) || (db_o != 32'h0)) begin
        chk("idle_port_b", 64'd1, 64'd0);
      end
      if (done_o || err_o) begin
        if (eq.size() == 0) chk("unexpected_event", {62'h0, done_o, err_o}, 64'd0);
        else begin
          e = eq.pop_front();
          chk("event_kind", {62'h0, done_o, err_o}, e.is_err ? 64'd1 : 64'd2);
          chk("event_cpu_rst", {63'h0, cpu_rst_o}, {63'h0, e.cpu});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  function automatic int rg(input int maxgap);
    return int'($urandom_range(0, maxgap));
  endfunction

  // WRITE frame carrying wbuf[0..len-1]; expectations from address arithmetic.
  task automatic send_write(input logic [31:0] addr, input int len, input bit bad_cs, input int maxgap);
    logic [7:0] s;
    logic [15:0] l;
    wr_t w;
    ev_t e;
    l = 16'(len);
    s = 8'h01;
    send_byte(8'hA5, rg(maxgap));
    m_cpu = 1'b1;
    send_byte(8'h01, rg(maxgap));
    for (int i = 0; i < 4; i++) begin s += addr[8*i +: 8]; send_byte(addr[8*i +: 8], rg(maxgap)); end
    s += l[7:0];  send_byte(l[7:0], rg(maxgap));
    s += l[15:8]; send_byte(l[15:8], rg(maxgap));
    for (int k = 0; k < len; k++) begin
      w.a = 32'((longint'(addr) + 4 * k) % G_SIZE);
      w.d = wbuf[k];
      wq.push_back(w);
      for (int i = 0; i < 4; i++) begin s += wbuf[k][8*i +: 8]; send_byte(wbuf[k][8*i +: 8], rg(maxgap)); end
    end
    e.is_err = bad_cs;
    e.cpu = m_cpu;
    eq.push_back(e);
    send_byte(bad_cs ? s + 8'd1 : s, rg(maxgap));
  endtask

  task automatic send_ctl(input logic [7:0] cmd, input bit good);
    ev_t e;
    send_byte(8'hA5, rg(2));
    send_byte(cmd, rg(2));
    if (good) m_cpu = (cmd == 8'h03);
    e.is_err = !good;
    e.cpu = m_cpu;
    eq.push_back(e);
    send_byte(good ? cmd : cmd + 8'd1, rg(2));
  endtask

  task automatic send_bad_cmd(input logic [7:0] cmd);
    ev_t e;
    e.is_err = 1'b1;
    e.cpu = m_cpu;
    eq.push_back(e);
    send_byte(8'hA5, rg(2));
    send_byte(cmd, rg(2));
  endtask

  task automatic send_bad_addr(input logic [31:0] addr);
    ev_t e;
    send_byte(8'hA5, rg(2));
    m_cpu = 1'b1;
    send_byte(8'h01, rg(2));
    e.is_err = 1'b1;
    e.cpu = m_cpu;
    eq.push_back(e);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], rg(2));
  endtask

  task automatic fill_random(input int len);
    for (int k = 0; k < len; k++) wbuf[k] = $urandom;
  endtask

  initial begin
    int cyc;
    bit seen;
    logic [7:0] b;
    logic [7:0] cmd;
    int kind;
    int len;
    ev_t e;

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ab_db", {ab_o, db_o}, 64'h0);
    chk("reset_ctrl", {56'h0, rx_ready_o, enb_o, web_o, |bweb_o, cpu_rst_o, busy_o, done_o, err_o},
        {56'h0, 8'b0000_1000});
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", {63'h0, rx_ready_o}, 64'd1);
    mon_en = 1'b1;

    wbuf[0] = 32'h11223344;
    wbuf[1] = 32'hAABBCCDD;
    send_write(32'h0000_0100, 2, 1'b0, 3);
    send_ctl(8'h02, 1'b1);
    send_ctl(8'h03, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("cpu_rst_after_bad_halt", {63'h0, cpu_rst_o}, 64'd0);

    fill_random(2);
    send_write(32'(G_SIZE - 4), 2, 1'b0, 2);
    send_bad_addr(32'h0000_0102);
    send_bad_cmd(8'h7F);
    repeat (3) send_byte(8'h00, 1);

    // Stalled frame: one data word half sent, then silence.
    e.is_err = 1'b1;
    send_byte(8'hA5, 0);
    m_cpu = 1'b1;
    e.cpu = m_cpu;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h5A, 0);
    eq.push_back(e);
    send_byte(8'h6B, 0);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (err_o) seen = 1'b1;
    end
    chk("timeout_cycles", 64'(cyc), 64'(G_TMO));
    chk("busy_after_timeout", {63'h0, busy_o}, 64'd0);

    // Reset in the middle of DATA.
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    send_byte(8'h00, 0); send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h77, 0); send_byte(8'h88, 0);
    rst = 1'b1;
    #1;
    chk("midreset_ab_db", {ab_o, db_o}, 64'h0);
    chk("midreset_ctrl", {56'h0, rx_ready_o, enb_o, web_o, |bweb_o, cpu_rst_o, busy_o, done_o, err_o},
        {56'h0, 8'b0000_1000});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_cpu = 1'b1;
    @(posedge clk); #1;
    fill_random(3);
    send_write(32'h0000_0300, 3, 1'b0, 1);

    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 6));
      case (kind)
        0, 1, 2: begin
          len = int'($urandom_range(0, 4));
          fill_random(len);
          send_write({$urandom_range(0, 16383), 2'b00} + 32'(($urandom_range(0, 3)) << 16),
                     len, ($urandom_range(0, 3) == 0), 3);
        end
        3: begin
          cmd = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'h03;
          send_ctl(cmd, ($urandom_range(0, 2) != 0));
        end
        4: begin
          b = 8'($urandom_range(4, 255));
          if (b == 8'hA5) b = 8'hFF;
          send_bad_cmd(b);
        end
        5: send_bad_addr({$urandom_range(0, 255), 2'b00} | 32'($urandom_range(1, 3)));
        default: begin
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h00;
          send_byte(b, rg(2));
        end
      endcase
    end

    repeat (5) @(posedge clk);
    #1;
    chk("final_cpu_rst", {63'h0, cpu_rst_o}, {63'h0, m_cpu});
    chk("writes_drained", 64'(wq.size()), 64'd0);
    chk("events_drained", 64'(eq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
